// File: rtl/div_clk_meas_if.sv
// div_clk_meas_if: signal bundle between a div_clk_meas instance and its user
//   i_en, i_sig                        : enable and measured signal into the meter
//   o_period, o_high, o_valid,
//   o_timeout, o_busy                  : measurement results and status out of the meter
interface div_clk_meas_if #(
    parameter int CNT_W = 16
);
    logic             i_en;
    logic             i_sig;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high;
    logic             o_valid;
    logic             o_timeout;
    logic             o_busy;
    modport master (output i_en, i_sig, input o_period, o_high, o_valid, o_timeout, o_busy);
    modport slave  (input i_en, i_sig, output o_period, o_high, o_valid, o_timeout, o_busy);
endinterface

// File: rtl/div_clk_meas.sv
// div_clk_meas: measures period and high time of a slow asynchronous square wave in clk cycles
//   clk, rst       : system clock, synchronous active-high reset
//   bus.i_en       : measurement enable
//   bus.i_sig      : measured signal, asynchronous to clk
//   bus.o_period   : last period, rise to rise
//   bus.o_high     : last high time, rise to fall
//   bus.o_valid    : one-cycle pulse when a new result is loaded
//   bus.o_timeout  : source stalled, cleared by the next o_valid
//   bus.o_busy     : measurement in progress
module div_clk_meas #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 2**CNT_W-1
) (
    input logic           clk,
    input logic           rst,
    div_clk_meas_if.slave bus
);
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, MEAS_HI, MEAS_LO} state_t;
    state_t           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, h_tmp_q, period_q, high_q;
    logic             valid_q, timeout_q, busy_q;
    logic             rise, fall, stall;
    logic [CNT_W-1:0] cnt_inc;
    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    // a rise coinciding with the limit is still a valid measurement
    assign stall   = (cnt_q == TO) & ~rise;
    assign cnt_inc = (cnt_q == TO) ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            h_tmp_q   <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            s1_q    <= bus.i_sig;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            valid_q <= 1'b0;
            if (!bus.i_en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (rise) begin
                        state_q <= MEAS_HI;
                        cnt_q   <= CNT_W'(1);
                        busy_q  <= 1'b1;
                    end
                    MEAS_HI: if (stall) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                    end else if (fall) begin
                        h_tmp_q <= cnt_q;
                        cnt_q   <= cnt_inc;
                        state_q <= MEAS_LO;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                    MEAS_LO: if (rise) begin
                        period_q  <= cnt_q;
                        high_q    <= h_tmp_q;
                        valid_q   <= 1'b1;
                        timeout_q <= 1'b0;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= MEAS_HI;
                    end else if (stall) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
    assign bus.o_period  = period_q;
    assign bus.o_high    = high_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_timeout = timeout_q;
    assign bus.o_busy    = busy_q;
endmodule

// File: tb/tb_div_clk_meas.sv
// tb_div_clk_meas: randomized self-checking bench for div_clk_meas against a waveform-level model
module tb_div_clk_meas;
    localparam int W  = 4;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    div_clk_meas_if #(.CNT_W(W)) bus ();
    div_clk_meas #(.CNT_W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    int errs   = 0;
    int checks = 0;
    int seg_h[$], seg_l[$], cap_p[$], cap_h[$];

    // every result pulse is logged; the model says each complete high/low segment
    // after the arming rise yields exactly one result of period h+l and high h
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) begin
            cap_p.push_back(int'(bus.o_period));
            cap_h.push_back(int'(bus.o_high));
        end
    end

    task automatic cyc(input logic v);
        bus.i_sig = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_segs();
        cap_p.delete();
        cap_h.delete();
        repeat (3) cyc(1'b0);
        foreach (seg_h[i]) begin
            repeat (seg_h[i]) cyc(1'b1);
            repeat (seg_l[i]) cyc(1'b0);
        end
        cyc(1'b1);
    endtask

    task automatic park();
        repeat (4) cyc(1'b0);
        bus.i_en = 1'b0;
        repeat (2) cyc(1'b0);
        bus.i_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_en = 1'b1;
        for (int i = 0; i < 3; i++) cyc(i[0]);
        checks++; if (bus.o_period !== 4'd0) begin errs++; $display("FAIL reset period: got %0d expected 0", bus.o_period); end
        checks++; if (bus.o_high !== 4'd0) begin errs++; $display("FAIL reset high: got %0d expected 0", bus.o_high); end
        checks++; if (bus.o_valid !== 1'b0) begin errs++; $display("FAIL reset valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_timeout !== 1'b0) begin errs++; $display("FAIL reset timeout: got %b expected 0", bus.o_timeout); end
        checks++; if (bus.o_busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b expected 0", bus.o_busy); end
        rst = 1'b0;
        park();
    endtask

    task automatic test_even();
        seg_h = {}; seg_l = {};
        repeat (5) begin seg_h.push_back(3); seg_l.push_back(3); end
        run_segs();
        park();
        checks++; if (cap_p.size() != seg_h.size()) begin errs++; $display("FAIL even count: got %0d expected %0d", cap_p.size(), seg_h.size()); end
        for (int i = 0; i < seg_h.size() && i < cap_p.size(); i++) begin
            checks++;
            if (cap_p[i] !== seg_h[i] + seg_l[i] || cap_h[i] !== seg_h[i]) begin
                errs++; $display("FAIL even[%0d]: got period=%0d high=%0d expected period=%0d high=%0d", i, cap_p[i], cap_h[i], seg_h[i] + seg_l[i], seg_h[i]);
            end
        end
    endtask

    task automatic test_odd();
        seg_h = {}; seg_l = {};
        repeat (4) begin seg_h.push_back(4); seg_l.push_back(3); end
        repeat (4) begin seg_h.push_back(2); seg_l.push_back(8); end
        run_segs();
        park();
        checks++; if (cap_p.size() != seg_h.size()) begin errs++; $display("FAIL odd count: got %0d expected %0d", cap_p.size(), seg_h.size()); end
        for (int i = 0; i < seg_h.size() && i < cap_p.size(); i++) begin
            checks++;
            if (cap_p[i] !== seg_h[i] + seg_l[i] || cap_h[i] !== seg_h[i]) begin
                errs++; $display("FAIL odd[%0d]: got period=%0d high=%0d expected period=%0d high=%0d", i, cap_p[i], cap_h[i], seg_h[i] + seg_l[i], seg_h[i]);
            end
        end
    endtask

    task automatic test_random();
        int p;
        seg_h = {1}; seg_l = {1};
        seg_h.push_back(7);  seg_l.push_back(8);
        seg_h.push_back(14); seg_l.push_back(1);
        repeat (20) begin
            p = int'($urandom_range(2, TO));
            seg_h.push_back(int'($urandom_range(1, p - 1)));
            seg_l.push_back(p - seg_h[$]);
        end
        run_segs();
        park();
        checks++; if (cap_p.size() != seg_h.size()) begin errs++; $display("FAIL random count: got %0d expected %0d", cap_p.size(), seg_h.size()); end
        for (int i = 0; i < seg_h.size() && i < cap_p.size(); i++) begin
            checks++;
            if (cap_p[i] !== seg_h[i] + seg_l[i] || cap_h[i] !== seg_h[i]) begin
                errs++; $display("FAIL random[%0d]: got period=%0d high=%0d expected period=%0d high=%0d", i, cap_p[i], cap_h[i], seg_h[i] + seg_l[i], seg_h[i]);
            end
        end
        checks++; if (bus.o_timeout !== 1'b0) begin errs++; $display("FAIL random timeout: got %b expected 0", bus.o_timeout); end
    endtask

    task automatic test_timeout();
        logic [W-1:0] p0;
        p0 = bus.o_period;
        cap_p.delete(); cap_h.delete();
        repeat (3) cyc(1'b0);
        // arming rise is sampled at the edge inside the first call; the stall is
        // flagged 17 edges later (2 sync + load + 14 counts to the limit)
        cyc(1'b1);
        cyc(1'b1);
        repeat (14) cyc(1'b0);
        cyc(1'b0);
        checks++; if (bus.o_timeout !== 1'b0) begin errs++; $display("FAIL timeout early: got %b expected 0", bus.o_timeout); end
        cyc(1'b0);
        checks++; if (bus.o_timeout !== 1'b1) begin errs++; $display("FAIL timeout set: got %b expected 1", bus.o_timeout); end
        checks++; if (bus.o_busy !== 1'b0) begin errs++; $display("FAIL timeout busy: got %b expected 0", bus.o_busy); end
        checks++; if (bus.o_period !== p0) begin errs++; $display("FAIL timeout period: got %0d expected %0d", bus.o_period, p0); end
        checks++; if (cap_p.size() != 0) begin errs++; $display("FAIL timeout valid: got %0d results expected 0", cap_p.size()); end
        repeat (5) cyc(1'b0);
        checks++; if (bus.o_timeout !== 1'b1) begin errs++; $display("FAIL timeout hold: got %b expected 1", bus.o_timeout); end
        seg_h = {3, 3, 3}; seg_l = {3, 3, 3};
        run_segs();
        park();
        checks++; if (bus.o_timeout !== 1'b0) begin errs++; $display("FAIL timeout clear: got %b expected 0", bus.o_timeout); end
        checks++; if (cap_p.size() != seg_h.size()) begin errs++; $display("FAIL resume count: got %0d expected %0d", cap_p.size(), seg_h.size()); end
        for (int i = 0; i < seg_h.size() && i < cap_p.size(); i++) begin
            checks++;
            if (cap_p[i] !== seg_h[i] + seg_l[i] || cap_h[i] !== seg_h[i]) begin
                errs++; $display("FAIL resume[%0d]: got period=%0d high=%0d expected period=%0d high=%0d", i, cap_p[i], cap_h[i], seg_h[i] + seg_l[i], seg_h[i]);
            end
        end
    endtask

    task automatic test_enable_drop();
        seg_h = {3, 3}; seg_l = {3, 3};
        run_segs();
        repeat (3) cyc(1'b0);
        checks++; if (bus.o_busy !== 1'b1) begin errs++; $display("FAIL drop busy before: got %b expected 1", bus.o_busy); end
        bus.i_en = 1'b0;
        cyc(1'b0);
        checks++; if (bus.o_busy !== 1'b0) begin errs++; $display("FAIL drop busy after: got %b expected 0", bus.o_busy); end
        cyc(1'b1);
        repeat (3) cyc(1'b0);
        checks++; if (cap_p.size() != 2) begin errs++; $display("FAIL drop count: got %0d expected 2", cap_p.size()); end
        checks++; if (bus.o_period !== 4'd6 || bus.o_high !== 4'd3) begin errs++; $display("FAIL drop hold: got period=%0d high=%0d expected period=6 high=3", bus.o_period, bus.o_high); end
        bus.i_en = 1'b1;
        seg_h = {3, 5}; seg_l = {4, 2};
        run_segs();
        park();
        checks++; if (cap_p.size() != seg_h.size()) begin errs++; $display("FAIL rearm count: got %0d expected %0d", cap_p.size(), seg_h.size()); end
        for (int i = 0; i < seg_h.size() && i < cap_p.size(); i++) begin
            checks++;
            if (cap_p[i] !== seg_h[i] + seg_l[i] || cap_h[i] !== seg_h[i]) begin
                errs++; $display("FAIL rearm[%0d]: got period=%0d high=%0d expected period=%0d high=%0d", i, cap_p[i], cap_h[i], seg_h[i] + seg_l[i], seg_h[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) cyc(1'b0);
        repeat (4) cyc(1'b1);
        checks++; if (bus.o_busy !== 1'b1) begin errs++; $display("FAIL mid busy armed: got %b expected 1", bus.o_busy); end
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        checks++; if (bus.o_period !== 4'd0 || bus.o_high !== 4'd0) begin errs++; $display("FAIL mid reset results: got period=%0d high=%0d expected 0", bus.o_period, bus.o_high); end
        checks++; if (bus.o_valid !== 1'b0 || bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b0) begin errs++; $display("FAIL mid reset flags: got valid=%b timeout=%b busy=%b expected 0", bus.o_valid, bus.o_timeout, bus.o_busy); end
        cap_p.delete(); cap_h.delete();
        repeat (3) cyc(1'b1);
        repeat (3) cyc(1'b0);
        checks++; if (bus.o_busy !== 1'b1) begin errs++; $display("FAIL mid rearm busy: got %b expected 1", bus.o_busy); end
        park();
        checks++; if (cap_p.size() != 0) begin errs++; $display("FAIL mid no valid: got %0d results expected 0", cap_p.size()); end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_en = 1'b0;
        bus.i_sig = 1'b0;
        test_reset();
        test_even();
        test_odd();
        test_random();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
